// File: rtl/mixn_tdm.sv
// Time-division multi-channel digital mixer: one ADC sample is swept across NRX
// phase accumulators, and each channel's external sin/cos result mixes the sample.
module mixn_tdm #(
    parameter int unsigned NRX     = 4,
    parameter int unsigned ADCW    = 12,
    parameter int unsigned PHW     = 32,
    parameter int unsigned NCO_LAT = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic signed [ADCW-1:0] adc,
    input  logic                   adc_valid,
    output logic                   busy,
    input  logic                   phi_we,
    input  logic [2:0]             phi_addr,
    input  logic [PHW-1:0]         phi_data,
    output logic [PHW-1:0]         phase_o,
    output logic                   phase_valid,
    input  logic signed [17:0]     sin_i,
    input  logic signed [17:0]     cos_i,
    output logic signed [17:0]     mix_i,
    output logic signed [17:0]     mix_q,
    output logic                   mix_valid,
    output logic [2:0]             mix_chan,
    output logic                   overrun,
    input  logic                   overrun_clr
);

    localparam int unsigned NSLOT = 8;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                 state, state_nx;
    logic [2:0]             chan, chan_nx;
    logic                   accept;
    logic [PHW-1:0]         acc     [NSLOT];
    logic [PHW-1:0]         inc_act [NSLOT];
    logic [PHW-1:0]         inc_sh  [NSLOT];
    logic signed [ADCW-1:0] sample;

    logic [NCO_LAT-1:0]     v_d;
    logic [2:0]             ch_d  [NCO_LAT];
    logic signed [ADCW-1:0] smp_d [NCO_LAT];
    logic                   prod_v;
    logic [2:0]             prod_ch;
    logic signed [ADCW+17:0] prod_i, prod_q;

    assign accept = (state == IDLE) && adc_valid;

    always_comb begin
        state_nx    = state;
        chan_nx     = chan;
        busy        = 1'b0;
        phase_valid = 1'b0;
        phase_o     = '0;
        case (state)
            IDLE: begin
                if (adc_valid) begin
                    state_nx = SWEEP;
                    chan_nx  = '0;
                end
            end
            SWEEP: begin
                busy        = 1'b1;
                phase_valid = 1'b1;
                phase_o     = acc[chan];
                chan_nx     = chan + 3'd1;
                if (chan == 3'(NRX - 1)) begin
                    state_nx = IDLE;
                    chan_nx  = '0;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            chan    <= '0;
            sample  <= '0;
            overrun <= 1'b0;
            for (int unsigned i = 0; i < NSLOT; i++) begin
                acc[i]     <= '0;
                inc_act[i] <= '0;
                inc_sh[i]  <= '0;
            end
        end else begin
            state <= state_nx;
            chan  <= chan_nx;
            // Shadow table is sampled before any same-cycle write lands in it.
            if (accept) begin
                sample <= adc;
                for (int unsigned i = 0; i < NSLOT; i++) inc_act[i] <= inc_sh[i];
            end
            if (state == SWEEP) acc[chan] <= acc[chan] + inc_act[chan];
            if (phi_we && (32'(phi_addr) < NRX)) inc_sh[phi_addr] <= phi_data;
            if (busy && adc_valid) overrun <= 1'b1;
            else if (overrun_clr)  overrun <= 1'b0;
        end
    end

    function automatic logic signed [17:0] rnd_sat(input logic signed [ADCW+17:0] p);
        logic signed [19:0] t;
        t = $signed({p[ADCW+17], p[ADCW+17:ADCW-1]}) + $signed({19'b0, p[ADCW-2]});
        if (t > 20'sd131071) return 18'sd131071;
        return t[17:0];
    endfunction

    // The sample travels with its channel tag so a back-to-back accept cannot
    // disturb products still in flight for the previous sweep.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v_d       <= '0;
            prod_v    <= 1'b0;
            prod_ch   <= '0;
            prod_i    <= '0;
            prod_q    <= '0;
            mix_valid <= 1'b0;
            mix_i     <= '0;
            mix_q     <= '0;
            mix_chan  <= '0;
            for (int unsigned k = 0; k < NCO_LAT; k++) begin
                ch_d[k]  <= '0;
                smp_d[k] <= '0;
            end
        end else begin
            v_d[0]   <= phase_valid;
            ch_d[0]  <= chan;
            smp_d[0] <= sample;
            for (int unsigned k = 1; k < NCO_LAT; k++) begin
                v_d[k]   <= v_d[k-1];
                ch_d[k]  <= ch_d[k-1];
                smp_d[k] <= smp_d[k-1];
            end
            prod_v    <= v_d[NCO_LAT-1];
            prod_ch   <= ch_d[NCO_LAT-1];
            prod_i    <= smp_d[NCO_LAT-1] * cos_i;
            prod_q    <= smp_d[NCO_LAT-1] * sin_i;
            mix_valid <= prod_v;
            if (prod_v) begin
                mix_i    <= rnd_sat(prod_i);
                mix_q    <= rnd_sat(prod_q);
                mix_chan <= prod_ch;
            end
        end
    end

endmodule

// File: tb/tb_mixn_tdm.sv
// Directed bench for mixn_tdm: hand-computed phases, mix values, timing,
// overrun handling, shadow-table semantics and mid-sweep reset.
module tb_mixn_tdm;

    localparam int NRX = 4, ADCW = 12, PHW = 32, NCO_LAT = 2;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [ADCW-1:0] adc = '0;
    logic            adc_valid = 1'b0;
    logic            busy;
    logic            phi_we = 1'b0;
    logic [2:0]      phi_addr = '0;
    logic [PHW-1:0]  phi_data = '0;
    logic [PHW-1:0]  phase_o;
    logic            phase_valid;
    logic [17:0]     sin_i = '0, cos_i = '0;
    logic [17:0]     mix_i, mix_q;
    logic            mix_valid;
    logic [2:0]      mix_chan;
    logic            overrun;
    logic            overrun_clr = 1'b0;

    always #5 clk = ~clk;

    mixn_tdm #(.NRX(NRX), .ADCW(ADCW), .PHW(PHW), .NCO_LAT(NCO_LAT)) dut (
        .clk(clk), .rst_n(rst_n), .adc(adc), .adc_valid(adc_valid), .busy(busy),
        .phi_we(phi_we), .phi_addr(phi_addr), .phi_data(phi_data),
        .phase_o(phase_o), .phase_valid(phase_valid), .sin_i(sin_i), .cos_i(cos_i),
        .mix_i(mix_i), .mix_q(mix_q), .mix_valid(mix_valid), .mix_chan(mix_chan),
        .overrun(overrun), .overrun_clr(overrun_clr)
    );

    int nvec = 0, nerr = 0;
    logic [31:0] ph_val [8];
    logic [17:0] mx_i [8], mx_q [8];
    logic [2:0]  mx_ch [8];
    int          mx_cyc [8];
    int          n_ph, n_mx;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One accepted sample plus 12 observed cycles; optional side events at sweep cycle k
    // (we_k = -1 writes during the accept cycle itself).
    task automatic run(input int a, input int c, input int s, input int drop_k,
                       input int clr_k, input int rst_k, input int we_k,
                       input int we_addr, input logic [31:0] we_data);
        int w;
        w = 0;
        while (busy && w < 20) begin
            tick;
            w++;
        end
        check("idle_wait", {63'b0, busy}, 64'd0);
        for (int i = 0; i < 8; i++) begin
            ph_val[i] = 'x;
            mx_i[i] = 'x;
            mx_q[i] = 'x;
            mx_ch[i] = 'x;
            mx_cyc[i] = -1;
        end
        n_ph = 0;
        n_mx = 0;
        adc = ADCW'(a);
        cos_i = 18'(c);
        sin_i = 18'(s);
        adc_valid = 1'b1;
        if (we_k == -1) begin
            phi_we = 1'b1;
            phi_addr = 3'(we_addr);
            phi_data = we_data;
        end
        tick;
        adc_valid = 1'b0;
        phi_we = 1'b0;
        for (int k = 0; k < 12; k++) begin
            if (phase_valid && n_ph < 8) begin
                ph_val[n_ph] = phase_o;
                n_ph++;
            end
            if (mix_valid && n_mx < 8) begin
                mx_i[n_mx] = mix_i;
                mx_q[n_mx] = mix_q;
                mx_ch[n_mx] = mix_chan;
                mx_cyc[n_mx] = k;
                n_mx++;
            end
            adc_valid = (k == drop_k);
            if (k == drop_k) adc = ADCW'(7);
            overrun_clr = (k == clr_k);
            rst_n = (k != rst_k);
            phi_we = (k == we_k);
            if (k == we_k) begin
                phi_addr = 3'(we_addr);
                phi_data = we_data;
            end
            tick;
        end
        adc_valid = 1'b0;
        overrun_clr = 1'b0;
        rst_n = 1'b1;
        phi_we = 1'b0;
    endtask

    task automatic chk_ph(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                          input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        e = '{e0, e1, e2, e3};
        check({tag, "_nph"}, 64'(n_ph), 64'(NRX));
        for (int k = 0; k < NRX; k++)
            check($sformatf("%s_ph%0d", tag, k), 64'(ph_val[k]), 64'(e[k]));
    endtask

    task automatic chk_mx(input string tag, input logic [17:0] ei, input logic [17:0] eq);
        check({tag, "_nmx"}, 64'(n_mx), 64'(NRX));
        for (int k = 0; k < NRX; k++) begin
            check($sformatf("%s_i%0d", tag, k), 64'(mx_i[k]), 64'(ei));
            check($sformatf("%s_q%0d", tag, k), 64'(mx_q[k]), 64'(eq));
            check($sformatf("%s_ch%0d", tag, k), 64'(mx_ch[k]), 64'(k));
            check($sformatf("%s_t%0d", tag, k), 64'(mx_cyc[k]), 64'(k + NCO_LAT + 2));
        end
    endtask

    localparam int NO = -9;

    initial begin
        rst_n = 1'b0;
        repeat (3) tick;
        check("rst_busy", {63'b0, busy}, 64'd0);
        check("rst_pv", {63'b0, phase_valid}, 64'd0);
        check("rst_mv", {63'b0, mix_valid}, 64'd0);
        check("rst_ovr", {63'b0, overrun}, 64'd0);
        check("rst_phase", 64'(phase_o), 64'd0);
        check("rst_mixi", 64'(mix_i), 64'd0);
        check("rst_mixq", 64'(mix_q), 64'd0);
        check("rst_chan", 64'(mix_chan), 64'd0);
        rst_n = 1'b1;
        tick;

        // 100 * 2048 >> 11 = 100 on I, Q = 0
        run(100, 2048, 0, NO, NO, NO, NO, 0, 32'h0);
        chk_ph("s1", 32'h0, 32'h0, 32'h0, 32'h0);
        chk_mx("s1", 18'd100, 18'd0);
        check("s1_busy_end", {63'b0, busy}, 64'd0);

        // -2048 * -131072 = 2^28 -> rounds to 131072 -> saturates at 131071
        run(-2048, -131072, 0, NO, NO, NO, NO, 0, 32'h0);
        chk_mx("sat", 18'h1FFFF, 18'd0);
        // 1 * 1024: only the rounding bit set -> 1
        run(1, 1024, 0, NO, NO, NO, NO, 0, 32'h0);
        chk_mx("rnd_up", 18'd1, 18'd0);
        // -1024 -> -0.5 rounds to 0; -3072 -> -1.5 rounds to -1
        run(-1, 1024, 3072, NO, NO, NO, NO, 0, 32'h0);
        chk_mx("rnd_neg", 18'd0, 18'h3FFFF);

        phi_we = 1'b1;
        phi_addr = 3'd1;
        phi_data = 32'h4000_0000;
        tick;
        phi_we = 1'b0;

        run(100, 2048, 0, NO, NO, NO, NO, 0, 32'h0);
        chk_ph("s5", 32'h0, 32'h0, 32'h0, 32'h0);
        run(100, 2048, 0, NO, NO, NO, NO, 0, 32'h0);
        chk_ph("s6", 32'h0, 32'h4000_0000, 32'h0, 32'h0);
        // drop on the 2nd sweep cycle: sweep and sample untouched, overrun set
        run(100, 2048, 0, 1, NO, NO, NO, 0, 32'h0);
        chk_ph("s7", 32'h0, 32'h8000_0000, 32'h0, 32'h0);
        chk_mx("drop", 18'd100, 18'd0);
        check("ovr_set", {63'b0, overrun}, 64'd1);
        overrun_clr = 1'b1;
        tick;
        overrun_clr = 1'b0;
        check("ovr_clr", {63'b0, overrun}, 64'd0);

        // drop and clear together keep overrun; chan2 write held in shadow
        run(100, 2048, 0, 2, 2, NO, 1, 2, 32'h1000_0000);
        chk_ph("s8", 32'h0, 32'hC000_0000, 32'h0, 32'h0);
        check("ovr_prio", {63'b0, overrun}, 64'd1);
        run(100, 2048, 0, NO, NO, NO, 2, 5, 32'h0000_FFFF);
        chk_ph("s9", 32'h0, 32'h0, 32'h0, 32'h0);
        run(100, 2048, 0, NO, NO, NO, -1, 3, 32'h0100_0000);
        chk_ph("s10", 32'h0, 32'h4000_0000, 32'h1000_0000, 32'h0);
        run(100, 2048, 0, NO, NO, NO, NO, 0, 32'h0);
        chk_ph("s11", 32'h0, 32'h8000_0000, 32'h2000_0000, 32'h0);
        run(100, 2048, 0, NO, NO, NO, NO, 0, 32'h0);
        chk_ph("s12", 32'h0, 32'hC000_0000, 32'h3000_0000, 32'h0100_0000);
        overrun_clr = 1'b1;
        tick;
        overrun_clr = 1'b0;

        // reset on the 2nd sweep cycle aborts everything in flight
        run(100, 2048, 0, NO, NO, 1, NO, 0, 32'h0);
        check("rst_nph", 64'(n_ph), 64'd2);
        check("rst_nmx", 64'(n_mx), 64'd0);
        check("rst_busy_after", {63'b0, busy}, 64'd0);
        check("rst_mixi_after", 64'(mix_i), 64'd0);
        run(100, 2048, 0, NO, NO, NO, NO, 0, 32'h0);
        chk_ph("post_rst1", 32'h0, 32'h0, 32'h0, 32'h0);
        chk_mx("post_rst1", 18'd100, 18'd0);
        run(100, 2048, 0, NO, NO, NO, NO, 0, 32'h0);
        chk_ph("post_rst2", 32'h0, 32'h0, 32'h0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule

// File: doc/mixn_tdm.md
MIXN_TDM -- requirements
Module: mixn_tdm

Interface
REQ-001 SHALL have parameter NRX, default 4, number of receiver channels (1..8).
REQ-002 SHALL have parameter ADCW, default 12, ADC sample width, signed.
REQ-003 SHALL have parameter PHW, default 32, phase accumulator and increment width.
REQ-004 SHALL have parameter NCO_LAT, default 2, cycles from phase_o to matching sin_i/cos_i.
REQ-005 SHALL have ports:
- clk  in  1  sole clock.
- rst_n  in  1  synchronous, active-low reset.
- adc  in  ADCW  signed ADC sample.
- adc_valid  in  1  sample strobe.
- busy  out  1  sweep in progress; adc_valid is ignored while high.
- phi_we  in  1  increment write strobe.
- phi_addr  in  3  channel index for the write.
- phi_data  in  PHW  phase increment for the write.
- phase_o  out  PHW  phase sent to the external sin/cos core.
- phase_valid  out  1  phase_o valid.
- sin_i, cos_i  in  18  signed two's-complement sine and cosine, NCO_LAT cycles after phase_o.
- mix_i, mix_q  out  18  signed mixed I and Q.
- mix_valid  out  1  mix_i/mix_q valid.
- mix_chan  out  3  channel of the current mix output.
- overrun  out  1  sticky flag: a sample was dropped.
- overrun_clr  in  1  clears overrun.

Function
REQ-006 SHALL implement FSM states IDLE and SWEEP.
REQ-007 In IDLE, adc_valid=1 SHALL do all of the following, then enter SWEEP with channel counter 0:
- latch adc into the sample register;
- copy all NRX shadow increments into the active increment table.
REQ-008 Each SWEEP cycle SHALL do all of the following:
- drive phase_o = acc[chan] and phase_valid=1;
- update acc[chan] <= acc[chan] + inc[chan], modulo 2^PHW;
- increment chan.
REQ-009 SHALL return to IDLE after issuing chan NRX-1; busy=1 exactly in SWEEP cycles, so one accepted sample occupies NRX+1 cycles minimum.
REQ-010 adc_valid while busy=1 SHALL be dropped and SHALL set overrun; the latched sample and the sweep SHALL be unaffected.
REQ-011 overrun_clr SHALL clear overrun; a simultaneous overrun event SHALL take priority, leaving overrun at 1.
REQ-012 phi_we SHALL write the shadow table at phi_addr at any time; writes with phi_addr >= NRX SHALL be ignored; a write becomes active only at the next accepted sample.
REQ-013 A phi_we in the accept cycle, to the same channel, SHALL be written to the shadow table but SHALL NOT reach the active table until the following accept.
REQ-014 The product SHALL be sample (ADCW) x cos_i for I and sample x sin_i for Q, full width ADCW+18, registered one cycle after sin_i/cos_i arrive.
REQ-015 Output SHALL be product bits [ADCW+16:ADCW-1] plus rounding bit [ADCW-2] (round half up); for ADCW=12 this is [28:11] + bit 10.
REQ-016 If rounding overflows past +131071, the output SHALL saturate to +131071; it SHALL NOT wrap.
REQ-017 Rounding and saturation SHALL be registered, so mix_valid for a channel rises NCO_LAT+2 cycles after its phase_valid.
REQ-018 mix_chan SHALL equal the issuing channel index; channels SHALL emerge in order 0..NRX-1, one per cycle.
REQ-019 The sample register SHALL be held unchanged until all NRX products of the sweep have been formed.

Reset
REQ-020 rst_n=0 at a clock edge SHALL force all of the following:
- FSM to IDLE, chan to 0;
- all accumulators, active and shadow increments to 0;
- busy, phase_valid, mix_valid, overrun to 0;
- mix_i, mix_q, mix_chan, phase_o to 0.
REQ-021 Reset mid-sweep SHALL abort the sweep; in-flight pipeline valids SHALL be cleared, and no mix_valid SHALL appear for that sweep after reset release.

Verification
REQ-022 NRX=4, all increments 0, adc=100, sin_i=0, cos_i=2048 -> mix_i=100 and mix_q=0 on four consecutive mix_valid cycles, mix_chan 0,1,2,3; first valid NCO_LAT+2 cycles after the first phase_valid.
REQ-023 inc[1]=0x40000000, three accepted samples -> phase_o for chan 1 = 0x0, 0x40000000, 0x80000000; chan 0 stays 0.
REQ-024 adc=-2048, cos_i=-131072 -> raw 268435456 rounds to 131072, which overflows -> mix_i=+131071 (saturated); adc=1, cos_i=1024 -> rounding bit set -> mix_i=1.
REQ-025 adc_valid pulsed on the 2nd SWEEP cycle -> overrun=1, sweep outputs unchanged; then overrun_clr -> overrun=0; then overrun_clr together with a new drop -> overrun stays 1.
REQ-026 phi_we to chan 2 during a sweep -> accumulator behaviour unchanged until the next accepted sample; phi_addr=5 with NRX=4 -> no effect.
REQ-027 rst_n=0 on the 2nd SWEEP cycle -> after release: busy=0, mix_valid never pulses, all phase_o values restart from 0.
